fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: RST -> FETCH (wait for mem_valid) -> EXEC (hold on stall) -> FETCH.
// Latency: 2 cycles minimum per instruction. The memory side waits on mem_valid, and the decoder side holds while stall is high.
module fetch_unit #(
  parameter int PC_WIDTH          = 8,
  parameter int PROGRAM_DataWidth = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cnt_wr_en,
  input  logic                         add_offset,
  input  logic [PC_WIDTH-1:0]          literal_adr,
  input  logic                         stall,
  output logic [PC_WIDTH-1:0]          mem_adr,
  output logic                         mem_rd_en,
  input  logic [PROGRAM_DataWidth-1:0] mem_data,
  input  logic                         mem_valid,
  output logic [PROGRAM_DataWidth-1:0] instruction,
  output logic                         instr_valid,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [15:0]                  instr_count
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic [PC_WIDTH-1:0]            r_pc;
  logic [PC_WIDTH-1:0]            w_pc_next;
  logic [PROGRAM_DataWidth-1:0]   r_ir;
  logic [15:0]                    r_instr_count;
  logic                           w_retire;
  logic                           w_load_ir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RST:   w_next_state = ST_FETCH;
      ST_FETCH: if (mem_valid) w_next_state = ST_EXEC;
      ST_EXEC:  if (!stall)    w_next_state = ST_FETCH;
      default:  w_next_state = ST_RST;
    endcase
  end

  // The outputs decode from state alone, so an asserted reset clears them without waiting for a clock edge.
  always_comb begin
    mem_rd_en   = 1'b0;
    instr_valid = 1'b0;
    instruction = '0;
    case (r_state)
      ST_FETCH: mem_rd_en = 1'b1;
      ST_EXEC: begin
        instr_valid = 1'b1;
        instruction = r_ir;
      end
      default: ;
    endcase
  end

  assign w_load_ir = (r_state == ST_FETCH) && mem_valid;
  assign w_retire  = (r_state == ST_EXEC) && !stall;

  // The offset has the same width as the PC, so a modulo-2^PC_WIDTH add already gives the sign-extended result.
  always_comb begin
    w_pc_next = r_pc + PC_WIDTH'(1);
    if (cnt_wr_en) begin
      if (add_offset) begin
        w_pc_next = r_pc + literal_adr;
      end else begin
        w_pc_next = literal_adr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= '0;
      r_ir          <= '0;
      r_instr_count <= '0;
    end else begin
      if (w_load_ir) begin
        r_ir <= mem_data;
      end
      if (w_retire) begin
        r_pc          <= w_pc_next;
        r_instr_count <= r_instr_count + 16'd1;
      end
    end
  end

  assign pc          = r_pc;
  assign mem_adr     = r_pc;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: the driver pushes each accepted fetch into a queue, and the monitor pops and checks it on entry to EXEC.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        cnt_wr_en;
  logic        add_offset;
  logic [7:0]  literal_adr;
  logic        stall;
  logic [7:0]  mem_adr;
  logic        mem_rd_en;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc;
  logic [15:0] instr_count;

  fetch_unit #(.PC_WIDTH(8), .PROGRAM_DataWidth(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .cnt_wr_en   (cnt_wr_en),
    .add_offset  (add_offset),
    .literal_adr (literal_adr),
    .stall       (stall),
    .mem_adr     (mem_adr),
    .mem_rd_en   (mem_rd_en),
    .mem_data    (mem_data),
    .mem_valid   (mem_valid),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .instr_count (instr_count)
  );

  typedef struct {
    logic [7:0]  adr;
    logic [15:0] data;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  m_pc   = 8'h00;
  logic [15:0] m_cnt  = 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference PC rule in plain integer arithmetic, with the offset read as a signed 8-bit value.
  function automatic logic [7:0] next_pc(input logic [7:0] cur, input logic wr,
                                         input logic ao, input logic [7:0] lit);
    int sum;
    int off;
    if (!wr) begin
      sum = int'(cur) + 1;
    end else if (!ao) begin
      sum = int'(lit);
    end else begin
      off = (int'(lit) > 127) ? int'(lit) - 256 : int'(lit);
      sum = int'(cur) + off;
    end
    sum = ((sum % 256) + 256) % 256;
    return 8'(sum);
  endfunction

  // Monitor: on the first EXEC cycle, pop the next expectation; on stalled EXEC cycles, the outputs must keep matching it.
  exp_t mon_cur;
  logic mon_prev_v = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      mon_prev_v = 1'b0;
    end else begin
      if (instr_valid) begin
        if (!mon_prev_v) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_exec", 32'(instr_valid), 32'd0);
          end else begin
            mon_cur = exp_q.pop_front();
          end
        end
        chk("exec_instruction", 32'(instruction), 32'(mon_cur.data));
        chk("exec_pc", 32'(pc), 32'(mon_cur.adr));
        chk("exec_count", 32'(instr_count), 32'(mon_cur.cnt));
        chk("exec_rd_en", 32'(mem_rd_en), 32'd0);
      end
      mon_prev_v = instr_valid;
    end
  end

  task automatic rnd_mem();
    mem_valid = 1'($urandom);
    mem_data  = 16'($urandom);
  endtask

  task automatic do_instr(input int dly, input int stl, input logic wr, input logic ao,
                          input logic [7:0] lit, input logic [15:0] d);
    int   guard;
    exp_t e;
    guard     = 0;
    mem_valid = 1'b0;
    while (!mem_rd_en && guard < 8) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("fetch_wait", 32'(mem_rd_en), 32'd1);
    chk("fetch_adr", 32'(mem_adr), 32'(m_pc));
    chk("fetch_nop", 32'(instruction), 32'd0);
    for (int i = 0; i < dly; i++) begin
      mem_data = 16'($urandom);
      @(posedge clk); #1;
      chk("wait_rd_en", 32'(mem_rd_en), 32'd1);
      chk("wait_nop", 32'(instruction), 32'd0);
      chk("wait_ivld", 32'(instr_valid), 32'd0);
    end
    mem_valid = 1'b1;
    mem_data  = d;
    e.adr  = m_pc;
    e.data = d;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
    stall       = (stl > 0);
    cnt_wr_en   = wr;
    add_offset  = ao;
    literal_adr = lit;
    @(posedge clk); #1;
    for (int i = 0; i < stl; i++) begin
      rnd_mem();
      @(posedge clk); #1;
    end
    stall = 1'b0;
    rnd_mem();
    @(posedge clk); #1;
    mem_valid = 1'b0;
    m_pc  = next_pc(m_pc, wr, ao, lit);
    m_cnt = m_cnt + 16'd1;
    chk("retire_pc", 32'(pc), 32'(m_pc));
    chk("retire_count", 32'(instr_count), 32'(m_cnt));
    chk("retire_to_fetch", 32'(mem_rd_en), 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    cnt_wr_en   = 1'b0;
    add_offset  = 1'b0;
    literal_adr = 8'h00;
    stall       = 1'b0;
    mem_data    = 16'h0000;
    mem_valid   = 1'b0;
    #3;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_ivld", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Back-to-back fetches with mem_valid ready immediately.
    for (int i = 0; i < 3; i++) do_instr(0, 0, 1'b0, 1'b0, 8'h00, 16'h4A25);
    chk("seq_pc", 32'(pc), 32'h03);
    chk("seq_count", 32'(instr_count), 32'd3);

    do_instr(3, 0, 1'b0, 1'b0, 8'h00, 16'hC3C3);

    // Absolute and relative branches.
    do_instr(0, 0, 1'b1, 1'b0, 8'h10, 16'h1111);
    do_instr(0, 0, 1'b1, 1'b0, 8'h20, 16'h2222);
    chk("abs_branch", 32'(pc), 32'h20);
    do_instr(1, 0, 1'b1, 1'b0, 8'h10, 16'h3333);
    do_instr(0, 0, 1'b1, 1'b1, 8'hFE, 16'h4444);
    chk("rel_branch", 32'(pc), 32'h0E);

    // Wrap-around cases.
    do_instr(0, 0, 1'b1, 1'b0, 8'hFF, 16'h5555);
    do_instr(0, 0, 1'b0, 1'b0, 8'h00, 16'h6666);
    chk("wrap_inc", 32'(pc), 32'h00);
    do_instr(0, 0, 1'b1, 1'b0, 8'hF0, 16'h7777);
    do_instr(2, 0, 1'b1, 1'b1, 8'h20, 16'h8888);
    chk("wrap_offset", 32'(pc), 32'h10);
    do_instr(0, 0, 1'b0, 1'b1, 8'h50, 16'h9999);
    chk("offset_ignored", 32'(pc), 32'h11);

    do_instr(0, 4, 1'b0, 1'b0, 8'h00, 16'hABCD);

    for (int n = 0; n < 150; n++) begin
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
    end

    // An asynchronous reset in the middle of FETCH abandons the fetch.
    do_instr(0, 0, 1'b1, 1'b0, 8'h33, 16'h0F0F);
    chk("pre_reset_adr", 32'(mem_adr), 32'h33);
    #2;
    reset     = 1'b1;
    mem_valid = 1'b1;
    mem_data  = 16'hBEEF;
    #1;
    chk("async_pc", 32'(pc), 32'd0);
    chk("async_adr", 32'(mem_adr), 32'd0);
    chk("async_rd_en", 32'(mem_rd_en), 32'd0);
    chk("async_ivld", 32'(instr_valid), 32'd0);
    chk("async_instr", 32'(instruction), 32'd0);
    chk("async_count", 32'(instr_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    m_pc  = 8'h00;
    m_cnt = 16'h0000;
    @(posedge clk); #1;
    chk("post_rst_fetch", 32'(mem_rd_en), 32'd1);
    chk("post_rst_nop", 32'(instruction), 32'd0);
    do_instr(0, 0, 1'b0, 1'b0, 8'h00, 16'h1234);
    do_instr(1, 1, 1'b0, 1'b0, 8'h00, 16'h5678);
    chk("post_rst_pc", 32'(pc), 32'h02);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
